// File: rtl/top_memoria_pkg.sv
// Shared definitions for the MIPS data-memory stage:
// load/store type codes, dump FSM states and clogb2.
package top_memoria_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        DBG_IDLE = 2'd0,
        DBG_DUMP = 2'd1,
        DBG_DONE = 2'd2
    } dbg_state_t;

    // Bits needed to represent value (clogb2(31) = 5).
    function automatic int clogb2(input int value);
        int v;
        clogb2 = 0;
        for (v = value; v > 0; v = v >> 1) begin
            clogb2 = clogb2 + 1;
        end
    endfunction

endpackage

// File: rtl/top_memoria_memoria_datos.sv
// Single-port synchronous data RAM, byte-enable write, read-first.
// Ports: clock, enable (gates read reg and write), byte_en, addr,
//        wdata, rdata (registered, old contents on a write).
module memoria_datos #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 10
) (
    input  logic                   clock,
    input  logic                   enable,
    input  logic [WIDTH/8-1:0]     byte_en,
    input  logic [ADDR_BITS-1:0]   addr,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (enable) begin
            rdata <= mem[addr];
            for (int b = 0; b < WIDTH / 8; b++) begin
                if (byte_en[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/top_memoria.sv
// MIPS MEM stage: data RAM, byte/half lanes, load extension, MEM/WB
// register and a debug FSM that dumps the RAM while the pipeline halts.
// Ports: i_clock, i_soft_reset (sync, high), i_enable_pipeline,
//   EX/MEM inputs (i_result, i_data_write_to_mem, i_registro_destino,
//   i_RegWrite/MemRead/MemWrite/MemtoReg, i_ls_type), i_debug_dump_start;
//   MEM/WB outputs (o_RegWrite, o_MemtoReg, o_read_data, o_result,
//   o_registro_destino), sticky o_misaligned, o_debug_* dump stream.
module top_memoria
    import top_memoria_pkg::*;
#(
    parameter int WIDTH_DATA_MEM     = 32,
    parameter int CANT_REGISTROS     = 32,
    parameter int CANT_BITS_ADDR_MEM = 10,
    parameter int CANT_BITS_LS_TYPE  = 3
) (
    input  logic                               i_clock,
    input  logic                               i_soft_reset,
    input  logic                               i_enable_pipeline,
    input  logic [WIDTH_DATA_MEM-1:0]          i_result,
    input  logic [WIDTH_DATA_MEM-1:0]          i_data_write_to_mem,
    input  logic [clogb2(CANT_REGISTROS-1)-1:0] i_registro_destino,
    input  logic                               i_RegWrite,
    input  logic                               i_MemRead,
    input  logic                               i_MemWrite,
    input  logic                               i_MemtoReg,
    input  logic [CANT_BITS_LS_TYPE-1:0]       i_ls_type,
    input  logic                               i_debug_dump_start,
    output logic                               o_RegWrite,
    output logic                               o_MemtoReg,
    output logic [WIDTH_DATA_MEM-1:0]          o_read_data,
    output logic [WIDTH_DATA_MEM-1:0]          o_result,
    output logic [clogb2(CANT_REGISTROS-1)-1:0] o_registro_destino,
    output logic                               o_misaligned,
    output logic [WIDTH_DATA_MEM-1:0]          o_debug_data,
    output logic [CANT_BITS_ADDR_MEM-1:0]      o_debug_addr,
    output logic                               o_debug_valid,
    output logic                               o_debug_done
);

    localparam int N = CANT_BITS_ADDR_MEM;

    logic [1:0]   lane;
    logic [N-1:0] word_idx;
    logic         unused_bits;

    assign lane        = i_result[1:0];
    assign word_idx    = i_result[N+1:2];
    assign unused_bits = ^i_result[WIDTH_DATA_MEM-1:N+2];

    // Access decode: byte enables, replicated store data, alignment.
    logic        is_byte;
    logic        is_half;
    logic        bad_lane;
    logic        misaligned;
    logic [3:0]  byte_en;
    logic [31:0] store_word;

    always_comb begin
        is_byte    = (i_ls_type == LS_B) || (i_ls_type == LS_BU);
        is_half    = (i_ls_type == LS_H) || (i_ls_type == LS_HU);
        byte_en    = 4'b1111;
        store_word = i_data_write_to_mem;
        bad_lane   = |lane;
        if (is_byte) begin
            byte_en    = 4'b0001 << lane;
            store_word = {4{i_data_write_to_mem[7:0]}};
            bad_lane   = 1'b0;
        end else if (is_half) begin
            byte_en    = lane[1] ? 4'b1100 : 4'b0011;
            store_word = {2{i_data_write_to_mem[15:0]}};
            bad_lane   = lane[0];
        end
        misaligned = (i_MemRead | i_MemWrite) & bad_lane;
    end

    // RAM port: the dump FSM owns it only while the pipeline is halted.
    dbg_state_t   state;
    logic [N-1:0] dump_cnt;
    logic         dump_own;
    logic         ram_en;
    logic [N-1:0] ram_addr;
    logic [3:0]   ram_be;
    logic [31:0]  ram_q;

    assign dump_own = (state == DBG_DUMP) & ~i_enable_pipeline;
    assign ram_en   = i_enable_pipeline | dump_own;
    assign ram_addr = dump_own ? dump_cnt : word_idx;
    assign ram_be   = (i_enable_pipeline & i_MemWrite & ~misaligned)
                    ? byte_en : 4'b0000;

    memoria_datos #(
        .WIDTH     (WIDTH_DATA_MEM),
        .ADDR_BITS (N)
    ) u_ram (
        .clock   (i_clock),
        .enable  (ram_en),
        .byte_en (ram_be),
        .addr    (ram_addr),
        .wdata   (store_word),
        .rdata   (ram_q)
    );

    // MEM/WB register.
    logic                         memread_q;
    logic [CANT_BITS_LS_TYPE-1:0] ls_q;
    logic [1:0]                   lane_q;
    logic                         use_hold;
    logic [31:0]                  hold_data;
    logic [31:0]                  load_val;

    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            o_RegWrite         <= 1'b0;
            o_MemtoReg         <= 1'b0;
            o_result           <= '0;
            o_registro_destino <= '0;
            o_misaligned       <= 1'b0;
            memread_q          <= 1'b0;
            ls_q               <= '0;
            lane_q             <= 2'b00;
            use_hold           <= 1'b0;
            hold_data          <= '0;
        end else if (i_enable_pipeline) begin
            o_RegWrite         <= i_RegWrite & ~misaligned;
            o_MemtoReg         <= i_MemtoReg;
            o_result           <= i_result;
            o_registro_destino <= i_registro_destino;
            o_misaligned       <= o_misaligned | misaligned;
            memread_q          <= i_MemRead & ~misaligned;
            ls_q               <= i_ls_type;
            lane_q             <= lane;
            use_hold           <= 1'b0;
        end else if (state == DBG_IDLE && i_debug_dump_start) begin
            // The dump reuses the RAM read register, so freeze the
            // visible load value until the pipeline moves again.
            hold_data <= o_read_data;
            use_hold  <= 1'b1;
        end
    end

    // Load lane select and extension from the registered RAM word.
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = ram_q[{lane_q, 3'b000} +: 8];
        sel_half = lane_q[1] ? ram_q[31:16] : ram_q[15:0];
        case (ls_q)
            LS_B:    load_val = {{24{sel_byte[7]}}, sel_byte};
            LS_BU:   load_val = {24'd0, sel_byte};
            LS_H:    load_val = {{16{sel_half[15]}}, sel_half};
            LS_HU:   load_val = {16'd0, sel_half};
            default: load_val = ram_q;
        endcase
        if (!memread_q) begin
            load_val = '0;
        end
    end

    assign o_read_data  = use_hold ? hold_data : load_val;
    assign o_debug_data = o_debug_valid ? ram_q : '0;

    // Debug dump FSM.
    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            state         <= DBG_IDLE;
            dump_cnt      <= '0;
            o_debug_addr  <= '0;
            o_debug_valid <= 1'b0;
            o_debug_done  <= 1'b0;
        end else begin
            unique case (state)
                DBG_IDLE: begin
                    o_debug_valid <= 1'b0;
                    o_debug_done  <= 1'b0;
                    if (i_debug_dump_start && !i_enable_pipeline) begin
                        state    <= DBG_DUMP;
                        dump_cnt <= '0;
                    end
                end
                DBG_DUMP: begin
                    if (i_enable_pipeline) begin
                        state         <= DBG_IDLE;
                        o_debug_valid <= 1'b0;
                    end else begin
                        o_debug_valid <= 1'b1;
                        o_debug_addr  <= dump_cnt;
                        dump_cnt      <= dump_cnt + 1'b1;
                        if (dump_cnt == {N{1'b1}}) begin
                            state <= DBG_DONE;
                        end
                    end
                end
                DBG_DONE: begin
                    o_debug_valid <= 1'b0;
                    o_debug_done  <= 1'b1;
                    state         <= DBG_IDLE;
                end
                default: begin
                    state <= DBG_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_top_memoria.sv
// Scoreboard bench for top_memoria with a 16-word RAM.
// Byte-level reference memory drives all expected values.
module tb_top_memoria;
    import top_memoria_pkg::*;

    localparam int AB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] result;
    logic [31:0] wdata;
    logic [4:0]  dst;
    logic        rw, mr, mw, m2r;
    logic [2:0]  ls;
    logic        dump_start;
    logic        o_rw, o_m2r;
    logic [31:0] o_rd, o_res;
    logic [4:0]  o_dst;
    logic        o_mis;
    logic [31:0] dbg_data;
    logic [AB-1:0] dbg_addr;
    logic        dbg_valid, dbg_done;

    always #5 clk = ~clk;

    top_memoria #(.CANT_BITS_ADDR_MEM(AB)) dut (
        .i_clock             (clk),
        .i_soft_reset        (rst),
        .i_enable_pipeline   (en),
        .i_result            (result),
        .i_data_write_to_mem (wdata),
        .i_registro_destino  (dst),
        .i_RegWrite          (rw),
        .i_MemRead           (mr),
        .i_MemWrite          (mw),
        .i_MemtoReg          (m2r),
        .i_ls_type           (ls),
        .i_debug_dump_start  (dump_start),
        .o_RegWrite          (o_rw),
        .o_MemtoReg          (o_m2r),
        .o_read_data         (o_rd),
        .o_result            (o_res),
        .o_registro_destino  (o_dst),
        .o_misaligned        (o_mis),
        .o_debug_data        (dbg_data),
        .o_debug_addr        (dbg_addr),
        .o_debug_valid       (dbg_valid),
        .o_debug_done        (dbg_done)
    );

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] res;
        logic [4:0]  dst;
        logic        mis;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    exp_t  exp_q[$];
    beat_t beat_q[$];
    exp_t  last_exp;
    logic [7:0] mem_m [64];
    logic  mis_m;
    int    n_checks;
    int    n_pass;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    task automatic compare_out();
        exp_t e;
        e = exp_q.pop_front();
        chk("regwrite", 32'(o_rw), 32'(e.rw));
        chk("memtoreg", 32'(o_m2r), 32'(e.m2r));
        chk("read_data", o_rd, e.rd);
        chk("result", o_res, e.res);
        chk("dest", 32'(o_dst), 32'(e.dst));
        chk("misaligned", 32'(o_mis), 32'(e.mis));
    endtask

    function automatic int size_of(input logic [2:0] t);
        if (t == LS_B || t == LS_BU) return 1;
        if (t == LS_H || t == LS_HU) return 2;
        return 4;
    endfunction

    task automatic issue(input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] t, input logic r, input logic w,
                         input logic rgw, input logic mtr,
                         input logic [4:0] d);
        exp_t e;
        int sz;
        int a;
        logic bad;
        logic [31:0] v;
        sz  = size_of(t);
        a   = int'(addr[5:0]);
        bad = (r | w) && ((a % sz) != 0);
        v   = 32'd0;
        if (r && !bad) begin
            for (int k = 0; k < sz; k++) v |= 32'(mem_m[a+k]) << (8 * k);
            if (t == LS_B) v = {{24{v[7]}}, v[7:0]};
            if (t == LS_H) v = {{16{v[15]}}, v[15:0]};
        end
        if (w && !bad) begin
            for (int k = 0; k < sz; k++) mem_m[a+k] = wd[8*k +: 8];
        end
        mis_m = mis_m | bad;
        e.rw  = rgw & ~bad;
        e.m2r = mtr;
        e.rd  = v;
        e.res = addr;
        e.dst = d;
        e.mis = mis_m;
        exp_q.push_back(e);
        last_exp = e;
        en = 1'b1; result = addr; wdata = wd; ls = t;
        mr = r; mw = w; rw = rgw; m2r = mtr; dst = d;
        @(posedge clk); #1;
        compare_out();
    endtask

    task automatic stall(input int n);
        en = 1'b0; result = 32'h20; wdata = 32'h1234; ls = LS_W;
        mr = 1'b0; mw = 1'b1; rw = 1'b1; m2r = 1'b0; dst = 5'd9;
        repeat (n) begin
            exp_q.push_back(last_exp);
            @(posedge clk); #1;
            compare_out();
        end
    endtask

    task automatic idle_inputs();
        result = '0; wdata = '0; ls = LS_W; dst = '0;
        mr = 1'b0; mw = 1'b0; rw = 1'b0; m2r = 1'b0; dump_start = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        en  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regwrite", 32'(o_rw), 32'd0);
        chk("rst_memtoreg", 32'(o_m2r), 32'd0);
        chk("rst_read_data", o_rd, 32'd0);
        chk("rst_result", o_res, 32'd0);
        chk("rst_dest", 32'(o_dst), 32'd0);
        chk("rst_misaligned", 32'(o_mis), 32'd0);
        chk("rst_dbg_valid", 32'(dbg_valid), 32'd0);
        chk("rst_dbg_done", 32'(dbg_done), 32'd0);
        rst = 1'b0;
        mis_m = 1'b0;
        last_exp = '0;
    endtask

    task automatic run_dump(input int abort_at);
        beat_t b;
        int beats, done_n, last_cyc, done_cyc, want_beats;
        for (int i = 0; i < 16; i++) begin
            b.addr = 32'(i);
            b.data = {mem_m[4*i+3], mem_m[4*i+2], mem_m[4*i+1], mem_m[4*i]};
            beat_q.push_back(b);
        end
        idle_inputs();
        en = 1'b0;
        dump_start = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b0;
        beats = 0; done_n = 0; last_cyc = -1; done_cyc = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 0 && abort_at < 0) chk("hold_read_data", o_rd, last_exp.rd);
            if (dbg_valid) begin
                if (beat_q.size() > 0) begin
                    b = beat_q.pop_front();
                    chk("dump_addr", 32'(dbg_addr), b.addr);
                    chk("dump_data", dbg_data, b.data);
                end
                beats++;
                last_cyc = cyc;
                if (beats == abort_at) en = 1'b1;
            end
            if (dbg_done) begin
                done_n++;
                done_cyc = cyc;
            end
        end
        want_beats = (abort_at < 0) ? 16 : abort_at;
        chk("dump_beats", 32'(beats), 32'(want_beats));
        chk("dump_done_count", 32'(done_n), (abort_at < 0) ? 32'd1 : 32'd0);
        if (abort_at < 0) chk("done_cycle", 32'(done_cyc), 32'(last_cyc + 1));
        beat_q.delete();
        en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mis_m    = 1'b0;
        last_exp = '0;
        rst      = 1'b1;
        en       = 1'b0;
        idle_inputs();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            issue(32'(4 * i), 32'hA000_0000 + 32'(i) * 32'h0101_0101,
                  LS_W, 1'b0, 1'b1, 1'b0, 1'b0, 5'(i));
        end
        issue(32'h10, 32'hDEADBEEF, LS_W,  1'b0, 1'b1, 1'b0, 1'b0, 5'd1);
        issue(32'h10, 32'h0,        LS_W,  1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
        issue(32'h11, 32'h80,       LS_B,  1'b0, 1'b1, 1'b0, 1'b0, 5'd3);
        issue(32'h11, 32'h0,        LS_B,  1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
        issue(32'h11, 32'h0,        LS_BU, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5);
        issue(32'h10, 32'h0,        LS_W,  1'b1, 1'b0, 1'b1, 1'b1, 5'd6);
        issue(32'h12, 32'h8001,     LS_H,  1'b0, 1'b1, 1'b0, 1'b0, 5'd7);
        issue(32'h12, 32'h0,        LS_H,  1'b1, 1'b0, 1'b1, 1'b1, 5'd8);
        issue(32'h12, 32'h0,        LS_HU, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
        issue(32'h13, 32'h11223344, LS_W,  1'b0, 1'b1, 1'b0, 1'b0, 5'd10);
        issue(32'h10, 32'h0,        LS_W,  1'b1, 1'b0, 1'b1, 1'b1, 5'd11);
        issue(32'h11, 32'h0,        LS_H,  1'b1, 1'b0, 1'b1, 1'b1, 5'd12);
        issue(32'h50, 32'h0,        LS_W,  1'b1, 1'b0, 1'b1, 1'b1, 5'd13);
        stall(3);
        issue(32'h20, 32'h0,        LS_W,  1'b1, 1'b0, 1'b1, 1'b1, 5'd14);
        issue(32'h24, 32'h5555AAAA, LS_W,  1'b1, 1'b1, 1'b1, 1'b1, 5'd15);
        issue(32'h24, 32'h0,        LS_W,  1'b1, 1'b0, 1'b1, 1'b1, 5'd16);
        issue(32'h2A, 32'h0,        LS_HU, 1'b1, 1'b0, 1'b1, 1'b0, 5'd17);
        do_reset();
        issue(32'h24, 32'h0,        LS_W,  1'b1, 1'b0, 1'b1, 1'b1, 5'd18);
        run_dump(-1);
        run_dump(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
